// File: rtl/serial_frame_tx.sv
// Byte-wide to serial frame transmitter: start bit, 8 data bits LSB first,
// optional even-parity bit, stop bit. tx is idle-high and comes straight from a flop.
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       reset_async,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [7:0] LP_TC = 8'(CLKS_PER_BIT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       r_tx;

    state_t     w_state_nx;
    logic [7:0] w_cnt_nx;
    logic [2:0] w_idx_nx;
    logic [7:0] w_shift_nx;
    logic       w_parity_nx;
    logic       w_tx_nx;
    logic       w_tc;

    assign w_tc = (r_cnt == LP_TC);

    // NOTE: every register is reset here, including the shift register, so an
    // aborted frame leaves no stale byte behind; sequential state uses <= only.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_shift  <= w_shift_nx;
            r_parity <= w_parity_nx;
            r_tx     <= w_tx_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = w_tc ? '0 : r_cnt + 8'd1;
        w_idx_nx    = r_idx;
        w_shift_nx  = r_shift;
        w_parity_nx = r_parity;
        w_tx_nx     = r_tx;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                w_tx_nx  = 1'b1;
                if (tx_valid) begin
                    // The start bit is loaded on the accept edge itself.
                    w_state_nx  = ST_START;
                    w_shift_nx  = tx_data;
                    w_parity_nx = ^tx_data;
                    w_idx_nx    = '0;
                    w_tx_nx     = 1'b0;
                end
            end
            ST_START: begin
                if (w_tc) begin
                    w_state_nx = ST_DATA;
                    w_idx_nx   = '0;
                    w_tx_nx    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    if (r_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            w_state_nx = ST_PARITY;
                            w_tx_nx    = r_parity;
                        end else begin
                            w_state_nx = ST_STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_idx_nx   = r_idx + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tc) begin
                    w_state_nx = ST_STOP;
                    w_tx_nx    = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_nx = 1'b1;
                if (w_tc) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one instance with parity, one without; a queue of
// expected frames is filled at accept time and drained by the serial-line sampler.
module tb_serial_frame_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        logic [7:0]  data;
    } frame_t;

    logic       clk;
    logic       reset_async;
    logic [7:0] tx_data;
    logic       r_valid;
    logic       sel_p;

    logic valid_p, ready_p, tx_p, busy_p;
    logic valid_n, ready_n, tx_n, busy_n;
    logic w_ready, w_tx, w_busy;

    frame_t sb_q[$];
    int     n_checks;
    int     n_pass;

    assign valid_p = r_valid & sel_p;
    assign valid_n = r_valid & ~sel_p;
    assign w_ready = sel_p ? ready_p : ready_n;
    assign w_tx    = sel_p ? tx_p    : tx_n;
    assign w_busy  = sel_p ? busy_p  : busy_n;

    serial_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_p (
        .clk         (clk),
        .reset_async (reset_async),
        .tx_data     (tx_data),
        .tx_valid    (valid_p),
        .tx_ready    (ready_p),
        .tx          (tx_p),
        .busy        (busy_p)
    );

    serial_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut_n (
        .clk         (clk),
        .reset_async (reset_async),
        .tx_data     (tx_data),
        .tx_valid    (valid_n),
        .tx_ready    (ready_n),
        .tx          (tx_n),
        .busy        (busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input bit par_en);
        frame_t f;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
        if (par_en) begin
            f.bits[9] = ^d;
            f.nbits   = 11;
        end else begin
            f.nbits   = 10;
        end
        f.data = d;
        return f;
    endfunction

    // Offer a byte, wait for the accept edge, record what the line must carry.
    task automatic send(input logic [7:0] d, input bit hold);
        logic rdy;
        bit   done;
        int   n;
        @(negedge clk);
        tx_data = d;
        r_valid = 1'b1;
        done    = 1'b0;
        n       = 0;
        while (!done) begin
            rdy = w_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    r_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        sb_q.push_back(make_frame(d, sel_p));
        #1;
        if (!hold) r_valid = 1'b0;
    endtask

    // Wait for a start bit, then compare every cycle of every bit with the head of the queue.
    task automatic rx_frame(output int gap);
        frame_t     f;
        logic [3:0] s;
        logic [7:0] rx_byte;
        bit         got;
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (w_tx === 1'b0) got = 1'b1;
            else gap++;
        end
        if (!got) begin
            check("rx_start_timeout", 32'd0, 32'd1);
            return;
        end
        check("busy_in_frame", {30'd0, w_busy, w_ready}, 32'd2);
        if (sb_q.size() == 0) begin
            check("rx_unexpected_frame", 32'd1, 32'd0);
            return;
        end
        f = sb_q.pop_front();
        rx_byte = '0;
        for (int b = 0; b < f.nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                s[c] = w_tx;
            end
            if (b >= 1 && b <= 8) rx_byte[b - 1] = s[0];
            check($sformatf("bit%0d_of_%02h", b, f.data), {28'd0, s}, {28'd0, {CPB{f.bits[b]}}});
        end
        check("rx_byte", {24'd0, rx_byte}, {24'd0, f.data});
    endtask

    task automatic post_frame(input string tag);
        @(negedge clk);
        check(tag, {29'd0, w_ready, w_busy, w_tx}, 32'b101);
    endtask

    task automatic quiet_line(input string tag, input int cycles);
        int zeros;
        zeros = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (w_tx !== 1'b1 || w_ready !== 1'b1) zeros++;
        end
        check(tag, zeros, 32'd0);
    endtask

    initial begin
        int gap;
        n_checks    = 0;
        n_pass      = 0;
        reset_async = 1'b1;
        r_valid     = 1'b0;
        tx_data     = '0;
        sel_p       = 1'b1;

        #2;
        check("reset_p", {29'd0, w_ready, w_busy, w_tx}, 32'b101);
        sel_p = 1'b0;
        #1;
        check("reset_n", {29'd0, w_ready, w_busy, w_tx}, 32'b101);
        sel_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_async = 1'b0;

        // 0xA5 with parity: 0,1,0,1,0,0,1,0,1,0,1
        send(8'hA5, 1'b0);
        rx_frame(gap);
        post_frame("idle_after_a5");

        // 0x01 without parity, 10 bit periods
        sel_p = 1'b0;
        send(8'h01, 1'b0);
        rx_frame(gap);
        post_frame("idle_after_01");

        // 0x07 with parity: odd number of ones, so parity bit is 1
        sel_p = 1'b1;
        send(8'h07, 1'b0);
        rx_frame(gap);
        post_frame("idle_after_07");

        // Back-to-back: valid held high, one idle clock between frames
        fork
            begin
                send(8'h3C, 1'b1);
                send(8'hC3, 1'b0);
            end
            begin
                rx_frame(gap);
                rx_frame(gap);
                check("b2b_gap", gap, 32'd1);
            end
        join
        post_frame("idle_after_c3");

        // tx_data changes mid-frame must not reach the line
        send(8'h00, 1'b0);
        fork
            rx_frame(gap);
            begin
                repeat (8) @(negedge clk);
                tx_data = 8'hFF;
            end
        join
        post_frame("idle_after_00");

        // tx_valid while busy: no effect, nothing queued
        send(8'h5A, 1'b0);
        fork
            rx_frame(gap);
            begin
                repeat (10) @(negedge clk);
                tx_data = 8'hE7;
                r_valid = 1'b1;
                repeat (20) @(negedge clk);
                r_valid = 1'b0;
            end
        join
        post_frame("idle_after_5a");
        quiet_line("no_frame_after_busy_valid", 60);

        // Reset during data bit 3 aborts the frame at once
        send(8'h96, 1'b0);
        sb_q.delete();
        repeat (17) @(posedge clk);
        #2;
        reset_async = 1'b1;
        #1;
        check("async_reset_mid_frame", {29'd0, w_ready, w_busy, w_tx}, 32'b101);
        tx_data = 8'h12;
        r_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r_valid = 1'b0;
        @(negedge clk);
        reset_async = 1'b0;
        quiet_line("no_frame_after_reset", 20);

        send(8'h55, 1'b0);
        rx_frame(gap);
        post_frame("idle_after_55");
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Parameters
REQ-001 SHALL provide CLKS_PER_BIT, default 4, meaning the number of clk cycles each serial bit is held on tx; legal values are 2..255.
REQ-002 SHALL provide PARITY_EN, default 1, meaning an even-parity bit is inserted after the data bits when 1 and omitted when 0.

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_async, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tx_data, input, 8 bits: parallel byte to transmit.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is offered this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle-high, driven directly from a flop.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line.

Function
REQ-010 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, each encoded in a registered state vector.
REQ-011 SHALL accept a byte on the rising edge where tx_valid=1 and tx_ready=1, capture tx_data into an 8-bit shift register on that edge, and move to START.
REQ-012 SHALL drive tx_ready=1 only in IDLE; tx_valid while tx_ready=0 is ignored and leaves no pending request.
REQ-013 SHALL put the start bit (tx=0) on tx the first cycle after accept (latency 1 clk).
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-period counter that counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the bit on terminal count.
REQ-015 SHALL, in DATA, send 8 bits LSB first, using a 3-bit bit index that runs 0..7; on index 7 at terminal count it moves to PARITY if PARITY_EN=1, else to STOP.
REQ-016 SHALL, in PARITY, send the XOR of the 8 captured bits (even parity: total count of ones in data plus parity is even).
REQ-017 SHALL, in STOP, drive tx=1 for one bit period, then return to IDLE with tx_ready=1 on the following cycle.
REQ-018 SHALL make the frame length 10 bit periods with PARITY_EN=0, or 11 bit periods with PARITY_EN=1; there are no extra idle cycles between the accept edge and the start bit.
REQ-019 SHALL allow back-to-back bytes: tx_valid held high in the first IDLE cycle after STOP is accepted, giving minimum inter-frame spacing of 1 clk of tx=1 beyond the stop bit.
REQ-020 SHALL ignore changes to tx_data after the accept edge for the rest of the frame.
REQ-021 SHALL drive busy=1 in START, DATA, PARITY and STOP, and busy=0 in IDLE; busy = ~tx_ready at all times.

Reset
REQ-022 SHALL, on reset_async=1, immediately and without a clock edge set state=IDLE, tx=1, tx_ready=1, busy=0, and clear the bit counter, bit index and shift register to 0.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame with no further bits sent and no queued byte.
REQ-024 SHALL ignore tx_valid while reset_async=1; operation resumes on the first rising clk edge after reset deasserts.

Verification (CLKS_PER_BIT=4)
REQ-025 SHALL pass this scenario: PARITY_EN=1, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,0,1, each 4 clk long, 44 clk total, then tx_ready=1.
REQ-026 SHALL pass this scenario: PARITY_EN=0, send 0x01 -> tx bits 0,1,0,0,0,0,0,0,0,1 (40 clk); send 0x07 with PARITY_EN=1 -> parity bit = 1.
REQ-027 SHALL pass this scenario: tx_valid held high with 0x3C then 0xC3 -> two complete frames separated by exactly 1 idle clk of tx=1; second frame carries 0xC3.
REQ-028 SHALL pass this scenario: tx_data changed to 0xFF during the DATA state of a 0x00 frame -> all data bits on tx remain 0.
REQ-029 SHALL pass this scenario: reset_async pulsed during data bit 3 -> tx=1, busy=0, tx_ready=1 within the same cycle (before next edge); next accepted byte 0x55 is sent as a full, correct frame.
REQ-030 SHALL pass this scenario: tx_valid=1 while busy=1 -> no effect on the current frame, and no frame follows unless tx_valid is still high in IDLE.
